lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: N, default 9, word-address width of the attached data memory (512 words x 32 bit).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  core access request; sampled only when o_ready=1.
REQ-005 i_we  input  1  1 = store, 0 = load.
REQ-006 i_funct3  input  3  RV32I width code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-007 i_addr  input  32  byte address.
REQ-008 i_wdata  input  32  store data, right-aligned.
REQ-009 o_ready  output  1  high only in IDLE.
REQ-010 o_valid  output  1  one-cycle completion pulse.
REQ-011 o_rdata  output  32  extended load result; valid while o_valid=1.
REQ-012 o_err  output  1  illegal funct3 flag; valid while o_valid=1.
REQ-013 o_mem_addr  output  N  word address to memory.
REQ-014 o_mem_wdata  output  32  lane-aligned store data.
REQ-015 o_mem_bmask  output  4  byte-lane enables; bit k = byte k.
REQ-016 o_mem_wren  output  1  memory write enable.
REQ-017 i_mem_rdata  input  32  combinational memory read data for o_mem_addr.

Function
REQ-018 FSM states SHALL be IDLE, ACC0, ACC1, DONE.
REQ-019 IDLE and i_req=1 SHALL latch i_we, i_funct3, i_addr, i_wdata and move to ACC0; legal codes only, else move to DONE with error set.
REQ-020 Legal codes: store 000/001/010; load 000/001/010/100/101; anything else is illegal and SHALL cause no memory access.
REQ-021 Fields: off = addr[1:0], w = addr[N+1:2]; addr[31:N+2] ignored.
REQ-022 Size = 1/2/4 bytes; split = (off + size > 4).
REQ-023 ACC0: o_mem_addr = w; bmask = (size mask << off) & 4'hF; o_mem_wdata = wdata << 8*off; o_mem_wren = we.
REQ-024 ACC0 SHALL move to ACC1 if split, else to DONE.
REQ-025 ACC1: o_mem_addr = w+1 mod 2^N (word 511 wraps to 0); bmask = size mask >> (4-off); o_mem_wdata = wdata >> 8*(4-off); o_mem_wren = we.
REQ-026 Loads SHALL capture i_mem_rdata at the end of each ACC cycle.
REQ-027 Assembled load: (rd0 >> 8*off) | (rd1 << 8*(4-off)), rd1 term used only if split.
REQ-028 Load result SHALL be truncated to size, then sign-extended for 000/001 and zero-extended for 100/101/010.
REQ-029 DONE: o_valid=1 for exactly one cycle; next state IDLE. o_rdata = load result, or 0 for stores and errors. o_err=1 only for illegal codes.
REQ-030 Latency from accept edge to o_valid: aligned 2 cycles, split 3, illegal 1.
REQ-031 Outside ACC states: o_mem_wren=0, o_mem_bmask=0, o_mem_wdata=0, o_mem_addr=0.
REQ-032 o_ready=0 in ACC0/ACC1/DONE; i_req is ignored there, so no back-to-back acceptance in DONE.
REQ-033 o_mem_wren SHALL never be high with o_mem_bmask=0.

Reset
REQ-034 i_reset=1 SHALL force IDLE and zero all registered state regardless of current state.
REQ-035 After reset: o_ready=1, o_valid=0, o_rdata=0, o_err=0, all o_mem_* = 0.
REQ-036 Reset during ACC0/ACC1 SHALL abort the access; any ACC1 half of a split access is not issued, and no o_valid is produced.

Verification
REQ-037 sw 0xDEADBEEF @0x10, then lw @0x10 -> ACC0 addr=4, bmask=1111; load o_rdata=0xDEADBEEF after 2 cycles.
REQ-038 sb 0x80 @0x21, then lb/lbu @0x21 -> bmask=0010, wdata=0x00008000; lb=0xFFFFFF80, lbu=0x00000080.
REQ-039 sw 0x11223344 @0x7FF -> ACC0 addr=511, bmask=1000, wdata=0x44000000; ACC1 addr=0, bmask=0111, wdata=0x00112233. lw @0x7FF -> 0x11223344, o_valid 3 cycles after accept.
REQ-040 lh @0x03 with word0=0xAB000000 and word1=0x000000CD -> o_rdata=0xFFFFCDAB.
REQ-041 funct3=011 load -> no memory access, o_valid after 1 cycle, o_err=1, o_rdata=0.
REQ-042 Split sw with i_reset asserted in ACC0 -> ACC1 write never issued, word1 unchanged, o_valid stays 0, o_ready=1 on the next cycle.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer for a word-wide data memory.
// Misaligned accesses that straddle a word boundary are split into two cycles.
module lsu_ctrl #(
  parameter int unsigned N = 9
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req,
  input  logic         i_we,
  input  logic [2:0]   i_funct3,
  input  logic [31:0]  i_addr,
  input  logic [31:0]  i_wdata,
  output logic         o_ready,
  output logic         o_valid,
  output logic [31:0]  o_rdata,
  output logic         o_err,
  output logic [N-1:0] o_mem_addr,
  output logic [31:0]  o_mem_wdata,
  output logic [3:0]   o_mem_bmask,
  output logic         o_mem_wren,
  input  logic [31:0]  i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t       r_state;
  state_t       w_next;

  logic         r_we;
  logic [2:0]   r_funct3;
  logic [1:0]   r_off;
  logic [N-1:0] r_w;
  logic [31:0]  r_wdata;
  logic [31:0]  r_rd0;
  logic [31:0]  r_rd1;
  logic         r_err;

  logic         w_accept;
  logic         w_req_legal;
  logic [2:0]   w_size;
  logic [3:0]   w_mask;
  logic         w_split;
  logic [7:0]   w_mask8;
  logic [63:0]  w_lane_data;
  logic [31:0]  w_raw;
  logic [31:0]  w_load;
  logic         w_unused;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  assign w_unused    = ^i_addr[31:N+2];
  assign w_accept    = (r_state == IDLE) && i_req;
  assign w_req_legal = is_legal(i_we, i_funct3);

  always_comb begin
    w_size = 3'd4;
    w_mask = 4'b1111;
    case (r_funct3[1:0])
      2'b00: begin
        w_size = 3'd1;
        w_mask = 4'b0001;
      end
      2'b01: begin
        w_size = 3'd2;
        w_mask = 4'b0011;
      end
      default: begin
        w_size = 3'd4;
        w_mask = 4'b1111;
      end
    endcase
  end

  assign w_split = ({1'b0, r_off} + w_size) > 3'd4;

  // One 8-lane / 64-bit shift covers both halves: low half goes to word w,
  // high half to word w+1, which equals the >>(4-off) form for the second cycle.
  assign w_mask8     = {4'b0000, w_mask} << r_off;
  assign w_lane_data = {32'b0, r_wdata} << {r_off, 3'b000};
  assign w_raw       = 32'({r_rd1, r_rd0} >> {r_off, 3'b000});

  always_comb begin
    w_load = w_raw;
    case (r_funct3)
      3'b000:  w_load = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_load = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_load = {24'b0, w_raw[7:0]};
      3'b101:  w_load = {16'b0, w_raw[15:0]};
      default: w_load = w_raw;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = w_req_legal ? ACC0 : DONE;
      end
      ACC0:    w_next = w_split ? ACC1 : DONE;
      ACC1:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // rd1 is cleared on accept so a non-split load contributes nothing from it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_w      <= '0;
      r_wdata  <= '0;
      r_rd0    <= '0;
      r_rd1    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= i_we;
        r_funct3 <= i_funct3;
        r_off    <= i_addr[1:0];
        r_w      <= i_addr[N+1:2];
        r_wdata  <= i_wdata;
        r_rd0    <= '0;
        r_rd1    <= '0;
        r_err    <= ~w_req_legal;
      end
      if ((r_state == ACC0) && !r_we)
        r_rd0 <= i_mem_rdata;
      if ((r_state == ACC1) && !r_we)
        r_rd1 <= i_mem_rdata;
    end
  end

  always_comb begin
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_rdata     = '0;
    o_err       = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    o_mem_wren  = 1'b0;
    case (r_state)
      IDLE: o_ready = 1'b1;
      ACC0: begin
        o_mem_addr  = r_w;
        o_mem_bmask = w_mask8[3:0];
        o_mem_wdata = w_lane_data[31:0];
        o_mem_wren  = r_we;
      end
      ACC1: begin
        o_mem_addr  = r_w + N'(1);
        o_mem_bmask = w_mask8[7:4];
        o_mem_wdata = w_lane_data[63:32];
        o_mem_wren  = r_we;
      end
      DONE: begin
        o_valid = 1'b1;
        o_err   = r_err;
        o_rdata = (!r_we && !r_err) ? w_load : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: behavioural byte-wise memory model and a
// scoreboard of expected completions, sampled on the falling clock edge.
module tb_lsu_ctrl;

  localparam int N = 9;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_req = 1'b0;
  logic         i_we = 1'b0;
  logic [2:0]   i_funct3 = '0;
  logic [31:0]  i_addr = '0;
  logic [31:0]  i_wdata = '0;
  logic         o_ready;
  logic         o_valid;
  logic [31:0]  o_rdata;
  logic         o_err;
  logic [N-1:0] o_mem_addr;
  logic [31:0]  o_mem_wdata;
  logic [3:0]   o_mem_bmask;
  logic         o_mem_wren;
  logic [31:0]  i_mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [512];

  lsu_ctrl #(.N(N)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_valid(o_valid), .o_rdata(o_rdata), .o_err(o_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  assign i_mem_rdata = mem[o_mem_addr];

  always @(posedge i_clk) begin
    if (o_mem_wren)
      for (int k = 0; k < 4; k++)
        if (o_mem_bmask[k]) mem[o_mem_addr][8*k +: 8] <= o_mem_wdata[8*k +: 8];
  end

  always @(negedge i_clk) begin
    if (o_mem_wren && (o_mem_bmask == 4'b0000)) begin
      n_err++;
      $display("FAIL wren_without_bmask: bmask=%b wren=%b", o_mem_bmask, o_mem_wren);
    end
  end

  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    exp_t e;
    int size, off, w, idx;
    logic legal;
    logic [31:0] res, word;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e.rdata = '0;
    e.err   = 1'b0;
    e.lat   = 1;
    if (!legal) begin
      e.err = 1'b1;
      return e;
    end
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    w     = int'(addr[10:2]);
    e.lat = (off + size > 4) ? 3 : 2;
    if (!we) begin
      res = '0;
      for (int i = 0; i < size; i++) begin
        idx = off + i;
        word = (idx < 4) ? mem[w] : mem[(w + 1) % 512];
        res[8*i +: 8] = word[8*(idx % 4) +: 8];
      end
      if (f3 == 3'd0 && res[7])  res[31:8]  = '1;
      if (f3 == 3'd1 && res[15]) res[31:16] = '1;
      e.rdata = res;
    end
    return e;
  endfunction

  // Leaves the bench at the falling edge just after the accepting rising edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit track);
    int guard = 0;
    while (!o_ready && guard < 5) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_ready_timeout: o_ready=%b required 1", o_ready);
    end
    if (track) sb_q.push_back(model(we, f3, addr));
    i_req    = 1'b1;
    i_we     = we;
    i_funct3 = f3;
    i_addr   = addr;
    i_wdata  = wdata;
    @(negedge i_clk);
    i_req = 1'b0;
  endtask

  task automatic collect(input int start, output int lat, output exp_t e, output bit have);
    lat = start;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_valid) lat = 0;
    have = (sb_q.size() != 0);
    if (have) e = sb_q.pop_front();
    else e = '{rdata: '0, err: 1'b0, lat: -1};
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_req   = 1'b0;
    repeat (2) @(negedge i_clk);
    n_vec++;
    if ({o_ready, o_valid, o_err, o_mem_wren} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/vld/err/wren=%b required 1000",
               {o_ready, o_valid, o_err, o_mem_wren});
    end
    n_vec++;
    if (o_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h required 00000000", o_rdata);
    end
    n_vec++;
    if ({o_mem_addr, o_mem_bmask, o_mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_membus: addr=%h bmask=%b wdata=%h required all 0",
               o_mem_addr, o_mem_bmask, o_mem_wdata);
    end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_word();
    int lat; exp_t e; bit have;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
    n_vec++;
    if ({o_ready, o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata} !==
        {1'b0, 1'b1, 9'd4, 4'b1111, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL sw_acc0: rdy=%b wren=%b addr=%0d bmask=%b wdata=%h required 0 1 4 1111 deadbeef",
               o_ready, o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata);
    end
    collect(1, lat, e, have);
    n_vec++;
    if (!have || lat != e.lat || o_rdata !== e.rdata || o_err !== e.err) begin
      n_err++;
      $display("FAIL sw_done: lat=%0d rdata=%h err=%b required %0d %h %b", lat, o_rdata, o_err, e.lat, e.rdata, e.err);
    end
    @(negedge i_clk);
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || mem[4] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL sw_after: valid=%b ready=%b mem4=%h required 0 1 deadbeef", o_valid, o_ready, mem[4]);
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    n_vec++;
    if ({o_mem_wren, o_mem_addr, o_mem_bmask} !== {1'b0, 9'd4, 4'b1111}) begin
      n_err++;
      $display("FAIL lw_acc0: wren=%b addr=%0d bmask=%b required 0 4 1111", o_mem_wren, o_mem_addr, o_mem_bmask);
    end
    collect(1, lat, e, have);
    n_vec++;
    if (!have || lat != 2 || o_rdata !== 32'hDEADBEEF || o_rdata !== e.rdata || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL lw_done: lat=%0d rdata=%h err=%b required 2 deadbeef 0", lat, o_rdata, o_err);
    end
  endtask

  task automatic test_byte();
    int lat; exp_t e; bit have;
    logic [31:0] want [2];
    logic [2:0]  f3s [2];
    want[0] = 32'hFFFFFF80; f3s[0] = 3'b000;
    want[1] = 32'h00000080; f3s[1] = 3'b100;
    issue(1'b1, 3'b000, 32'h21, 32'h80, 1'b1);
    n_vec++;
    if ({o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata} !== {1'b1, 9'd8, 4'b0010, 32'h00008000}) begin
      n_err++;
      $display("FAIL sb_acc0: wren=%b addr=%0d bmask=%b wdata=%h required 1 8 0010 00008000",
               o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata);
    end
    collect(1, lat, e, have);
    n_vec++;
    if (!have || lat != e.lat || o_rdata !== 32'h0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL sb_done: lat=%0d rdata=%h err=%b required %0d 0 0", lat, o_rdata, o_err, e.lat);
    end
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, f3s[i], 32'h21, 32'h0, 1'b1);
      collect(1, lat, e, have);
      n_vec++;
      if (!have || lat != 2 || o_rdata !== want[i] || o_rdata !== e.rdata) begin
        n_err++;
        $display("FAIL byte_load_f3_%0d: lat=%0d rdata=%h required 2 %h", f3s[i], lat, o_rdata, want[i]);
      end
    end
  endtask

  task automatic test_split_wrap();
    int lat; exp_t e; bit have;
    issue(1'b1, 3'b010, 32'h7FF, 32'h11223344, 1'b1);
    n_vec++;
    if ({o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata} !== {1'b1, 9'd511, 4'b1000, 32'h44000000}) begin
      n_err++;
      $display("FAIL split_sw_acc0: wren=%b addr=%0d bmask=%b wdata=%h required 1 511 1000 44000000",
               o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata);
    end
    @(negedge i_clk);
    n_vec++;
    if ({o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata} !== {1'b1, 9'd0, 4'b0111, 32'h00112233}) begin
      n_err++;
      $display("FAIL split_sw_acc1: wren=%b addr=%0d bmask=%b wdata=%h required 1 0 0111 00112233",
               o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata);
    end
    collect(2, lat, e, have);
    n_vec++;
    if (!have || lat != 3 || o_rdata !== 32'h0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL split_sw_done: lat=%0d rdata=%h err=%b required 3 0 0", lat, o_rdata, o_err);
    end
    n_vec++;
    if (mem[511][31:24] !== 8'h44 || mem[0][23:0] !== 24'h112233) begin
      n_err++;
      $display("FAIL split_sw_mem: mem511=%h mem0=%h required 44xxxxxx xx112233", mem[511], mem[0]);
    end
    issue(1'b0, 3'b010, 32'h7FF, 32'h0, 1'b1);
    collect(1, lat, e, have);
    n_vec++;
    if (!have || lat != 3 || o_rdata !== 32'h11223344 || o_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL split_lw: lat=%0d rdata=%h required 3 11223344", lat, o_rdata);
    end
  endtask

  task automatic test_half_split();
    int lat; exp_t e; bit have;
    issue(1'b1, 3'b010, 32'h0, 32'hAB000000, 1'b1);
    collect(1, lat, e, have);
    issue(1'b1, 3'b010, 32'h4, 32'h000000CD, 1'b1);
    collect(1, lat, e, have);
    n_vec++;
    if (mem[0] !== 32'hAB000000 || mem[1] !== 32'h000000CD) begin
      n_err++;
      $display("FAIL half_preload: mem0=%h mem1=%h required ab000000 000000cd", mem[0], mem[1]);
    end
    issue(1'b0, 3'b001, 32'h3, 32'h0, 1'b1);
    collect(1, lat, e, have);
    n_vec++;
    if (!have || lat != 3 || o_rdata !== 32'hFFFFCDAB || o_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL lh_split: lat=%0d rdata=%h required 3 ffffcdab", lat, o_rdata);
    end
  endtask

  task automatic test_illegal();
    int lat; exp_t e; bit have;
    issue(1'b0, 3'b011, 32'h40, 32'h0, 1'b1);
    n_vec++;
    if ({o_mem_wren, o_mem_bmask, o_mem_addr} !== '0) begin
      n_err++;
      $display("FAIL illegal_ld_bus: wren=%b bmask=%b addr=%0d required 0 0000 0", o_mem_wren, o_mem_bmask, o_mem_addr);
    end
    collect(1, lat, e, have);
    n_vec++;
    if (!have || lat != 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL illegal_ld_done: lat=%0d err=%b rdata=%h required 1 1 0", lat, o_err, o_rdata);
    end
    issue(1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, 1'b1);
    collect(1, lat, e, have);
    n_vec++;
    if (!have || lat != 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || mem[0] !== 32'hAB000000) begin
      n_err++;
      $display("FAIL illegal_st: lat=%0d err=%b rdata=%h mem0=%h required 1 1 0 ab000000",
               lat, o_err, o_rdata, mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    int second_at = 0;
    exp_t e;
    int guard = 0;
    while (!o_ready && guard < 5) begin
      @(negedge i_clk);
      guard++;
    end
    sb_q.push_back(model(1'b0, 3'b101, 32'h12));
    sb_q.push_back(model(1'b0, 3'b101, 32'h12));
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b101; i_addr = 32'h12; i_wdata = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_clk);
      if (o_valid) begin
        nv++;
        if (nv == 2) second_at = c;
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra_valid: cycle %0d has no expected entry", c);
        end else begin
          e = sb_q.pop_front();
          if (o_rdata !== e.rdata || o_rdata !== 32'h0000DEAD || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_data: rdata=%h ready=%b required 0000dead 0", o_rdata, o_ready);
          end
        end
      end
      if (c == 4) i_req = 1'b0;
    end
    n_vec++;
    if (nv != 2 || second_at != 5) begin
      n_err++;
      $display("FAIL b2b_timing: valids=%0d second_at=%0d required 2 5", nv, second_at);
    end
  endtask

  task automatic test_load_sweep();
    int lat; exp_t e; bit have;
    logic [2:0] f3s [8];
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4;
    f3s[4] = 3'd5; f3s[5] = 3'd3; f3s[6] = 3'd6; f3s[7] = 3'd7;
    issue(1'b1, 3'b010, 32'h50, $urandom | 32'h80008080, 1'b1);
    collect(1, lat, e, have);
    issue(1'b1, 3'b010, 32'h54, $urandom, 1'b1);
    collect(1, lat, e, have);
    for (int i = 0; i < 8; i++) begin
      for (int off = 0; off < 4; off++) begin
        issue(1'b0, f3s[i], 32'h50 + off, 32'h0, 1'b1);
        collect(1, lat, e, have);
        n_vec++;
        if (!have || lat != e.lat || o_rdata !== e.rdata || o_err !== e.err) begin
          n_err++;
          $display("FAIL sweep_f3_%0d_off_%0d: lat=%0d rdata=%h err=%b required %0d %h %b",
                   f3s[i], off, lat, o_rdata, o_err, e.lat, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat; exp_t e; bit have;
    int nv = 0;
    issue(1'b1, 3'b010, 32'h4, 32'h5A5A5A5A, 1'b1);
    collect(1, lat, e, have);
    issue(1'b1, 3'b010, 32'h2, 32'hCAFEF00D, 1'b0);
    n_vec++;
    if ({o_mem_wren, o_mem_addr, o_mem_bmask} !== {1'b1, 9'd0, 4'b1100}) begin
      n_err++;
      $display("FAIL abort_acc0: wren=%b addr=%0d bmask=%b required 1 0 1100", o_mem_wren, o_mem_addr, o_mem_bmask);
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    n_vec++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_mem_wren !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: ready=%b valid=%b wren=%b required 1 0 0", o_ready, o_valid, o_mem_wren);
    end
    i_reset = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_valid || o_mem_wren) nv++;
    end
    n_vec++;
    if (nv != 0 || mem[1] !== 32'h5A5A5A5A) begin
      n_err++;
      $display("FAIL abort_after: stray_cycles=%0d mem1=%h required 0 5a5a5a5a", nv, mem[1]);
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_split_wrap();
    test_half_split();
    test_illegal();
    test_back_to_back();
    test_load_sweep();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
